// File: rtl/weight_multibank_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : weight_multibank_buffer                                       |
// | Purpose  : N-bank rotating weight buffer (loader -> MAC array) with      |
// |            fill/release handshakes; optional row parity (WMEM_PARITY_EN).|
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module weight_multibank_buffer #(
  parameter int DATA_W  = 8,
  parameter int N_DIM   = 4,
  parameter int DEPTH   = 1024,
  parameter int N_BANKS = 2,
  parameter int AW      = $clog2(DEPTH)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            wr_en,
  input  logic [AW-1:0]                   wr_addr,
  input  logic [N_DIM*DATA_W-1:0]         wr_data,
  input  logic                            wr_last,
  output logic                            wr_ready,
  input  logic                            rd_en,
  input  logic [AW-1:0]                   rd_addr,
  input  logic                            mode,
  output logic                            rd_ready,
  input  logic                            rd_release,
  output logic                            rd_valid,
  output logic [N_DIM*N_DIM*DATA_W-1:0]   rd_data,
  output logic                            rd_par_err,
  output logic [N_BANKS-1:0]              bank_full
);

  localparam int C_ROW_W     = N_DIM * DATA_W;
  localparam int C_LOG_N     = $clog2(N_DIM);
  localparam int C_RPB       = DEPTH / N_DIM;
  localparam int C_SUB_DEPTH = N_BANKS * C_RPB;
  localparam int C_IW        = $clog2(C_SUB_DEPTH);
  localparam int C_BW        = $clog2(N_BANKS);
  localparam logic [C_BW-1:0] C_LAST_BANK = C_BW'(N_BANKS - 1);

  logic [C_BW-1:0]              r_wr_bank;
  logic [C_BW-1:0]              r_rd_bank;
  logic [N_BANKS-1:0]           r_bank_full;
  logic                         r_rd_valid;
  logic [N_DIM*C_ROW_W-1:0]     r_rd_data;

  logic                         w_wr_acc;
  logic                         w_rd_acc;
  logic                         w_release;
  logic [C_LOG_N-1:0]           w_wr_sub;
  logic [C_LOG_N-1:0]           w_rd_sub;
  logic [C_IW-1:0]              w_wr_idx;
  logic [C_IW-1:0]              w_rd_idx;
  logic [C_ROW_W-1:0]           w_sub_row [N_DIM];
  logic [N_DIM*C_ROW_W-1:0]     w_tile;

  assign wr_ready  = !r_bank_full[r_wr_bank];
  assign rd_ready  = r_bank_full[r_rd_bank];
  assign bank_full = r_bank_full;
  assign rd_valid  = r_rd_valid;
  assign rd_data   = r_rd_data;

  assign w_wr_acc  = wr_en && wr_ready;
  assign w_rd_acc  = rd_en && rd_ready;
  assign w_release = rd_release && rd_ready;

  // Rows interleave across sub-arrays on the low address bits; each sub-array
  // holds C_RPB rows per bank, so one index reads an aligned N_DIM-row tile.
  assign w_wr_sub = wr_addr[C_LOG_N-1:0];
  assign w_rd_sub = rd_addr[C_LOG_N-1:0];
  assign w_wr_idx = C_IW'(r_wr_bank) * C_IW'(C_RPB) + C_IW'(wr_addr >> C_LOG_N);
  assign w_rd_idx = C_IW'(r_rd_bank) * C_IW'(C_RPB) + C_IW'(rd_addr >> C_LOG_N);

`ifdef WMEM_PARITY_EN
  logic [N_DIM-1:0] w_sub_perr;
  logic             w_par_err;
  logic             r_rd_par_err;
`endif

  for (genvar s = 0; s < N_DIM; s++) begin : g_sub
    logic [C_ROW_W-1:0] r_mem [C_SUB_DEPTH];

    always_ff @(posedge clk) begin
      if (w_wr_acc && (w_wr_sub == C_LOG_N'(s))) begin
        r_mem[w_wr_idx] <= wr_data;
      end
    end

    assign w_sub_row[s] = r_mem[w_rd_idx];

`ifdef WMEM_PARITY_EN
    logic r_par [C_SUB_DEPTH];

    always_ff @(posedge clk) begin
      if (w_wr_acc && (w_wr_sub == C_LOG_N'(s))) begin
        r_par[w_wr_idx] <= ^wr_data;
      end
    end

    assign w_sub_perr[s] = (^w_sub_row[s]) ^ r_par[w_rd_idx];
`endif
  end

  always_comb begin
    w_tile = '0;
    if (mode) begin
      w_tile[C_ROW_W-1:0] = w_sub_row[w_rd_sub];
    end else begin
      for (int r = 0; r < N_DIM; r++) begin
        w_tile[r*C_ROW_W +: C_ROW_W] = w_sub_row[r];
      end
    end
  end

`ifdef WMEM_PARITY_EN
  assign w_par_err  = mode ? w_sub_perr[w_rd_sub] : |w_sub_perr;
  assign rd_par_err = r_rd_par_err;
`else
  assign rd_par_err = 1'b0;
`endif

  // wr_last and an effective release always target different banks, since the
  // fill bank must be empty and the compute bank full.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_bank    <= '0;
      r_rd_bank    <= '0;
      r_bank_full  <= '0;
      r_rd_valid   <= 1'b0;
      r_rd_data    <= '0;
`ifdef WMEM_PARITY_EN
      r_rd_par_err <= 1'b0;
`endif
    end else begin
      r_rd_valid <= w_rd_acc;
      if (w_rd_acc) begin
        r_rd_data    <= w_tile;
`ifdef WMEM_PARITY_EN
        r_rd_par_err <= w_par_err;
`endif
      end
      if (w_wr_acc && wr_last) begin
        r_bank_full[r_wr_bank] <= 1'b1;
        r_wr_bank <= (r_wr_bank == C_LAST_BANK) ? '0 : r_wr_bank + 1'b1;
      end
      if (w_release) begin
        r_bank_full[r_rd_bank] <= 1'b0;
        r_rd_bank <= (r_rd_bank == C_LAST_BANK) ? '0 : r_rd_bank + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
